dcache_wb_buffer: RTL

Write-back buffer on the memory side of the D-cache. It accepts dirty victim lines the cache evicts during a fill and queues them in FIFO order. It drains them to memory as BUS_STORE commands whenever the memory arbiter grants the bus. Load misses can search it so they never read stale memory data. A flush request drains the buffer completely and then returns a one-cycle `flush_done`.

---
 rtl/dcache_wb_buffer_if.sv | 46 ++++
 rtl/dcache_wb_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer_if.sv
// Bus bundle between the D-cache side, the memory arbiter and the
// write-back buffer. The slave modport is the buffer's view; the master
// modport is the view of whatever drives the buffer (cache + memory side).
interface dcache_wb_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Victim push from the cache fill path
    logic          evict_valid;
    logic [63:0]   evict_addr;
    logic [63:0]   evict_data;
    logic          evict_ready;

    // Load-miss search
    logic [63:0]   lookup_addr;
    logic          lookup_hit;
    logic [63:0]   lookup_data;

    // Memory side
    logic          mem_grant;
    logic [1:0]    proc2mem_command;
    logic [63:0]   proc2mem_addr;
    logic [63:0]   proc2mem_data;
    logic [3:0]    mem2proc_response;

    // Flush and status
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  evict_valid, evict_addr, evict_data, lookup_addr,
               mem_grant, mem2proc_response, flush_req,
        output evict_ready, lookup_hit, lookup_data, proc2mem_command,
               proc2mem_addr, proc2mem_data, flush_done, count, empty
    );

    modport master (
        output evict_valid, evict_addr, evict_data, lookup_addr,
               mem_grant, mem2proc_response, flush_req,
        input  evict_ready, lookup_hit, lookup_data, proc2mem_command,
               proc2mem_addr, proc2mem_data, flush_done, count, empty
    );
endinterface

// File: rtl/dcache_wb_buffer.sv
// D-cache write-back buffer: circular FIFO of dirty victim lines drained to
// memory as BUS_STORE commands on granted cycles, searchable by load misses,
// with a flush mode that drains everything and pulses flush_done once.
module dcache_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    dcache_wb_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    head_ptr_reg;
    logic [PW-1:0]    tail_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [63:3]      addr_reg [DEPTH];
    logic [63:0]      data_reg [DEPTH];

    logic             buf_empty;
    logic             ready_int;
    logic             push;
    logic             issue;
    logic             pop;
    logic [DEPTH-1:0] match;
    logic             hit_int;
    logic [63:0]      hit_data;
    logic [PW-1:0]    scan_idx;

    assign buf_empty = (count_reg == '0);
    // No bypass: space freed by a pop only becomes usable after the edge.
    assign ready_int = (count_reg < CW'(DEPTH)) && (state_reg == RUN);
    assign push      = bus.evict_valid && ready_int;
    // Command is driven in the granted cycle itself, no extra stage.
    assign issue     = !buf_empty && bus.mem_grant && !reset;
    assign pop       = issue && (bus.mem2proc_response != 4'd0);

    // Per-entry address compare on line granularity
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match[gi] = valid_reg[gi] &&
                           (addr_reg[gi] == bus.lookup_addr[63:3]);
    end

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        hit_int  = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_ptr_reg + PW'(i);
            if (match[scan_idx]) begin
                hit_int  = 1'b1;
                hit_data = data_reg[scan_idx];
            end
        end
    end

    // Flush-mode FSM; leaves FLUSH the cycle the buffer is seen empty
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN:     if (bus.flush_req) state_reg <= FLUSH;
                FLUSH:   if (buf_empty)     state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    // Pointers, occupancy and valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
            valid_reg    <= '0;
        end else begin
            if (pop) begin
                valid_reg[head_ptr_reg] <= 1'b0;
                head_ptr_reg            <= head_ptr_reg + PW'(1);
            end
            if (push) begin
                valid_reg[tail_ptr_reg] <= 1'b1;
                tail_ptr_reg            <= tail_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Line payload storage; contents are qualified by valid_reg
    always_ff @(posedge clock) begin
        if (push) begin
            addr_reg[tail_ptr_reg] <= bus.evict_addr[63:3];
            data_reg[tail_ptr_reg] <= bus.evict_data;
        end
    end

    assign bus.evict_ready      = ready_int;
    assign bus.lookup_hit       = hit_int;
    assign bus.lookup_data      = hit_data;
    assign bus.proc2mem_command = issue ? BUS_STORE : BUS_NONE;
    assign bus.proc2mem_addr    = issue ? {addr_reg[head_ptr_reg], 3'b000} : 64'd0;
    assign bus.proc2mem_data    = issue ? data_reg[head_ptr_reg] : 64'd0;
    assign bus.flush_done       = (state_reg == FLUSH) && buf_empty && !reset;
    assign bus.count            = count_reg;
    assign bus.empty            = buf_empty;
endmodule
